// File: rtl/rda_pkg.sv
// Shared types and constants for the recursive-doubling adder result path.
package rda_pkg;

  localparam int unsigned RDA_WIDTH = 32;
  localparam int unsigned RDA_LAT   = 2;
  localparam int unsigned RDA_TAG_W = 8;

  typedef logic [RDA_TAG_W-1:0] rda_tag_t;

  typedef struct packed {
    logic [RDA_WIDTH-1:0] sum;
    logic                 cout;
    logic                 zero;
    logic                 ovf;
    rda_tag_t             tag;
  } rda_result_t;

  typedef struct packed {
    logic     v;
    logic     a_msb;
    logic     b_msb;
    rda_tag_t tag;
  } rda_track_t;

  // Two's-complement overflow: like-signed operands produced an opposite-signed sum.
  function automatic logic signed_ovf(logic a_msb, logic b_msb, logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/rda_result_queue_if.sv
// Operand-issue, adder-return and result handshake signals of the RDA result queue.
interface rda_result_queue_if #(
  parameter int unsigned WIDTH = 32
);

  logic             op_valid;
  logic             op_ready;
  logic             op_a_msb;
  logic             op_b_msb;
  logic             op_fire;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_zero;
  logic             out_ovf;
  logic [7:0]       out_tag;

  // Environment side: operand source, adder datapath and result consumer.
  modport master (
    output op_valid, op_a_msb, op_b_msb, sum_in, cout_in, out_ready,
    input  op_ready, op_fire, out_valid, out_sum, out_cout, out_zero, out_ovf, out_tag
  );

  // Queue side.
  modport slave (
    input  op_valid, op_a_msb, op_b_msb, sum_in, cout_in, out_ready,
    output op_ready, op_fire, out_valid, out_sum, out_cout, out_zero, out_ovf, out_tag
  );

endinterface

// File: rtl/rda_sync_fifo.sv
// DEPTH-entry synchronous FIFO of adder results; read data is the head, or the
// last popped entry while empty.
module rda_sync_fifo
  import rda_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  rda_result_t     wr_data,
  input  logic            rd_en,
  output rda_result_t     rd_data,
  output logic [CntW-1:0] count,
  output logic            empty,
  output logic            full
);

  rda_result_t     mem_q [DEPTH];
  rda_result_t     last_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;
  assign do_rd = rd_en && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      if (wr_en && !do_rd) begin
        count_q <= count_q + 1'b1;
      end else if (!wr_en && do_rd) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // When full, a simultaneous pop frees the head slot that the new tail entry reuses.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = empty ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/rda_result_queue.sv
// Credit-based issue tracker and result FIFO behind the pipelined RDA; WIDTH must
// equal RDA_WIDTH since the stored result type is fixed in the package.
module rda_result_queue
  import rda_pkg::*;
#(
  parameter int unsigned WIDTH = RDA_WIDTH,
  parameter int unsigned LAT   = RDA_LAT,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned InfW = $clog2(LAT + 1),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  rda_result_queue_if.slave    bus,
  output logic [InfW-1:0]      inflight,
  output logic [CntW-1:0]      count
);

  rda_track_t      track_q [LAT];
  rda_track_t      push;
  rda_track_t      tail;
  rda_tag_t        tag_q;
  logic [InfW-1:0] inflight_q;
  logic [31:0]     occupancy;
  logic            issue_fire;
  logic            capture;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  rda_result_t     wr_data;
  rda_result_t     rd_data;

  // Credit depends only on registered state, so every add in flight owns a FIFO slot.
  assign occupancy    = 32'(count) + 32'(inflight_q);
  assign bus.op_ready = (occupancy < DEPTH);
  assign issue_fire   = bus.op_valid && bus.op_ready;
  assign bus.op_fire  = issue_fire;

  always_comb begin
    push = '0;
    if (issue_fire) begin
      push.v     = 1'b1;
      push.a_msb = bus.op_a_msb;
      push.b_msb = bus.op_b_msb;
      push.tag   = tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        track_q[i] <= '0;
      end
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      track_q[0] <= push;
      for (int i = 1; i < LAT; i++) begin
        track_q[i] <= track_q[i-1];
      end
      if (issue_fire) begin
        tag_q <= tag_q + 1'b1;
      end
      if (issue_fire && !capture) begin
        inflight_q <= inflight_q + 1'b1;
      end else if (!issue_fire && capture) begin
        inflight_q <= inflight_q - 1'b1;
      end
    end
  end

  // The tail entry lines up with the adder's sum output LAT edges after issue.
  assign tail    = track_q[LAT-1];
  assign capture = tail.v;

  always_comb begin
    wr_data      = '0;
    wr_data.sum  = bus.sum_in;
    wr_data.cout = bus.cout_in;
    wr_data.zero = ~|bus.sum_in;
    wr_data.ovf  = signed_ovf(tail.a_msb, tail.b_msb, bus.sum_in[WIDTH-1]);
    wr_data.tag  = tail.tag;
  end

  assign pop = bus.out_valid && bus.out_ready;

  rda_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign inflight      = inflight_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_sum   = rd_data.sum;
  assign bus.out_cout  = rd_data.cout;
  assign bus.out_zero  = rd_data.zero;
  assign bus.out_ovf   = rd_data.ovf;
  assign bus.out_tag   = rd_data.tag;

  no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(capture && fifo_full && !pop));

endmodule

// File: tb/tb_rda_result_queue.sv
// Randomised bench for rda_result_queue: the bench plays the adder and checks every
// cycle against a queue-level model of issue, capture and drain.
module tb_rda_result_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        zero;
    logic        ovf;
    logic [7:0]  tag;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
    int          due;
  } pend_t;

  logic                       clk;
  logic                       rst;
  logic [$clog2(LAT+1)-1:0]   inflight;
  logic [$clog2(DEPTH+1)-1:0] count;

  rda_result_queue_if #(.WIDTH(WIDTH)) bus ();

  rda_result_queue #(
    .WIDTH (WIDTH),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .inflight (inflight),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus intent and model state.
  logic        opv, ordy, rst_v;
  logic [31:0] a_v, b_v;
  pend_t       pend_q[$];
  res_t        res_q[$];
  res_t        last_r;
  logic [7:0]  tag_n;
  int          edge_n;
  logic        mdl_fire;
  int          n_cmp, n_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Expected result from plain arithmetic: 33-bit unsigned sum and 64-bit signed range check.
  function automatic res_t mk(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    logic [32:0] s;
    longint      ss;
    res_t        r;
    s      = {1'b0, a} + {1'b0, b};
    ss     = longint'($signed(a)) + longint'($signed(b));
    r.sum  = s[31:0];
    r.cout = s[32];
    r.zero = (s[31:0] == 32'd0);
    r.ovf  = (ss != longint'($signed(s[31:0])));
    r.tag  = t;
    return r;
  endfunction

  task automatic model_update();
    logic  ready, pop, cap;
    pend_t p;
    mdl_fire = 1'b0;
    if (rst_v) begin
      pend_q.delete();
      res_q.delete();
      last_r = '0;
      tag_n  = '0;
    end else begin
      ready    = (res_q.size() + pend_q.size()) < DEPTH;
      mdl_fire = opv && ready;
      pop      = (res_q.size() > 0) && ordy;
      cap      = (pend_q.size() > 0) && (pend_q[0].due == edge_n);
      if (pop) last_r = res_q.pop_front();
      if (cap) begin
        p = pend_q.pop_front();
        res_q.push_back(mk(p.a, p.b, p.tag));
      end
      if (mdl_fire) begin
        p.a   = a_v;
        p.b   = b_v;
        p.tag = tag_n;
        p.due = edge_n + LAT;
        pend_q.push_back(p);
        tag_n++;
      end
    end
  endtask

  task automatic compare();
    res_t h;
    logic ev;
    int   occ;
    ev  = res_q.size() > 0;
    h   = ev ? res_q[0] : last_r;
    occ = res_q.size() + pend_q.size();
    chk("op_ready",  bus.op_ready,  occ < DEPTH);
    chk("op_fire",   bus.op_fire,   opv && (occ < DEPTH));
    chk("out_valid", bus.out_valid, ev);
    chk("count",     count,         res_q.size());
    chk("inflight",  inflight,      pend_q.size());
    chk("out_sum",   bus.out_sum,   h.sum);
    chk("out_cout",  bus.out_cout,  h.cout);
    chk("out_zero",  bus.out_zero,  h.zero);
    chk("out_ovf",   bus.out_ovf,   h.ovf);
    chk("out_tag",   bus.out_tag,   h.tag);
  endtask

  // One clock: drive inputs (adder output included), update model at the edge, check at negedge.
  task automatic step();
    logic [32:0] s;
    bus.op_valid  = opv;
    bus.op_a_msb  = a_v[31];
    bus.op_b_msb  = b_v[31];
    bus.out_ready = ordy;
    rst           = rst_v;
    if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
      s = {1'b0, pend_q[0].a} + {1'b0, pend_q[0].b};
      bus.sum_in  = s[31:0];
      bus.cout_in = s[32];
    end else begin
      bus.sum_in  = $urandom;
      bus.cout_in = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    model_update();
    edge_n++;
    @(negedge clk);
    compare();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int fires;
    int k;
    n_cmp = 0; n_err = 0; edge_n = 0; tag_n = '0; last_r = '0;
    opv = 0; ordy = 0; rst_v = 1; a_v = '0; b_v = '0;
    bus.op_valid = 0; bus.op_a_msb = 0; bus.op_b_msb = 0;
    bus.out_ready = 0; bus.sum_in = '0; bus.cout_in = 0; rst = 1;
    step(); step();
    rst_v = 0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count",     count,         0);
    chk("rst_inflight",  inflight,      0);
    chk("rst_op_ready",  bus.op_ready,  1);
    chk("rst_out_sum",   bus.out_sum,   0);
    chk("rst_out_tag",   bus.out_tag,   0);

    // Single add 1 + 0xFFFFFFFF.
    opv = 1; a_v = 32'h0000_0001; b_v = 32'hFFFF_FFFF; step();
    opv = 0; step();
    chk("t1_not_yet", bus.out_valid, 0);
    step();
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_sum",   bus.out_sum,   32'h0);
    chk("t1_cout",  bus.out_cout,  1);
    chk("t1_zero",  bus.out_zero,  1);
    chk("t1_ovf",   bus.out_ovf,   0);
    chk("t1_tag",   bus.out_tag,   0);
    ordy = 1; step(); ordy = 0;

    // Signed overflow 0x7FFFFFFF + 1.
    opv = 1; a_v = 32'h7FFF_FFFF; b_v = 32'h0000_0001; step();
    opv = 0; step(); step();
    chk("t2_sum",  bus.out_sum,  32'h8000_0000);
    chk("t2_ovf",  bus.out_ovf,  1);
    chk("t2_zero", bus.out_zero, 0);
    chk("t2_cout", bus.out_cout, 0);
    chk("t2_tag",  bus.out_tag,  1);
    ordy = 1; step(); ordy = 0;
    chk("t2_hold_valid", bus.out_valid, 0);
    chk("t2_hold_sum",   bus.out_sum,   32'h8000_0000);

    // Back-pressure: op_valid held, consumer stalled.
    rst_v = 1; step(); rst_v = 0;
    opv = 1; ordy = 0; fires = 0;
    for (int i = 0; i < 8; i++) begin
      a_v = $urandom; b_v = $urandom;
      step();
      fires += int'(mdl_fire);
    end
    chk("t3_issues",   fires,        4);
    chk("t3_op_ready", bus.op_ready, 0);
    chk("t3_count",    count,        4);
    ordy = 1; k = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_q.size() > 0 && k < 4) begin
        chk("t3_drain_tag", bus.out_tag, k);
        k++;
      end
      a_v = $urandom; b_v = $urandom;
      step();
    end

    // Full-rate streaming.
    rst_v = 1; step(); rst_v = 0;
    opv = 1; ordy = 1;
    for (int i = 0; i < 300; i++) begin
      a_v = pick(); b_v = pick();
      step();
      if (i >= 2) chk("t4_no_bubble", bus.out_valid, 1);
      chk("t4_count_le1", count <= 1, 1);
    end

    // Reset with two in flight and two queued.
    rst_v = 1; step(); rst_v = 0;
    opv = 1; ordy = 0;
    for (int i = 0; i < 4; i++) begin
      a_v = $urandom; b_v = $urandom;
      step();
    end
    chk("t5_pre_count",    count,    2);
    chk("t5_pre_inflight", inflight, 2);
    opv = 0; rst_v = 1; step(); rst_v = 0;
    chk("t5_valid",    bus.out_valid, 0);
    chk("t5_count",    count,         0);
    chk("t5_inflight", inflight,      0);
    chk("t5_op_ready", bus.op_ready,  1);
    step(); step(); step();
    opv = 1; a_v = 32'd5; b_v = 32'd6; step();
    opv = 0; step(); step();
    chk("t5_new_valid", bus.out_valid, 1);
    chk("t5_new_tag",   bus.out_tag,   0);
    chk("t5_new_sum",   bus.out_sum,   32'd11);

    // Capture and pop on the same edge with the FIFO holding three.
    rst_v = 1; step(); rst_v = 0;
    opv = 1; ordy = 0;
    for (int i = 0; i < 5; i++) begin
      a_v = $urandom; b_v = $urandom;
      step();
    end
    chk("t6_pre_count",    count,       3);
    chk("t6_pre_inflight", inflight,    1);
    chk("t6_pre_tag",      bus.out_tag, 0);
    opv = 0; ordy = 1; step();
    chk("t6_count", count,       3);
    chk("t6_tag",   bus.out_tag, 1);
    for (int i = 0; i < 4; i++) step();
    ordy = 0;

    // Random traffic with bursts of back-pressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 < 100) begin
        opv  = 1;
        ordy = ($urandom % 8) == 0;
      end else begin
        opv  = ($urandom % 4) != 0;
        ordy = ($urandom % 3) != 0;
      end
      rst_v = ($urandom % 250) == 0;
      a_v = pick(); b_v = pick();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
